// File: rtl/rv_ctrl_pkg.sv
// ============================================================================
// Module      : rv_ctrl_pkg
// Description : State, opcode and control-field encodings for rv_multicycle_ctrl
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // ALU operation class handed from the FSM to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_STEP = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

`default_nettype wire

// File: rtl/rv_alu_decoder.sv
// ============================================================================
// Module      : rv_alu_decoder
// Description : Maps ALU operation class and instruction fields to alu_control
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_alu_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic [1:0] alu_op,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type distinguishes sub; addi with IR[30] set is still add
                    3'b000:  alu_control = (op == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/rv_multicycle_ctrl.sv
// ============================================================================
// Module      : rv_multicycle_ctrl
// Description : Multi-cycle RV32I-subset controller with retire counter,
//               memory-timeout watchdog and sticky trap state
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int RET_W   = 32,
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       result_src,
    output logic [2:0]       imm_src,
    output logic [2:0]       alu_control,
    output logic [RET_W-1:0] retired,
    output logic             trap,
    output logic [1:0]       trap_cause
);

    localparam logic [TO_W-1:0] C_WAIT_LIMIT = TO_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [RET_W-1:0] retired_q, retired_d;
    logic [TO_W-1:0]  wait_q, wait_d;
    logic [1:0]       trap_cause_q, trap_cause_d;
    logic [1:0]       w_alu_op;
    logic             w_retire;
    logic             w_waiting;

    rv_alu_decoder u_alu_decoder (
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .alu_op      (w_alu_op),
        .alu_control (alu_control)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= FETCH;
            retired_q    <= '0;
            wait_q       <= '0;
            trap_cause_q <= CAUSE_NONE;
        end else begin
            state_q      <= state_d;
            retired_q    <= retired_d;
            wait_q       <= wait_d;
            trap_cause_q <= trap_cause_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        trap_cause_d = trap_cause_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        adr_src      = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        reg_write    = 1'b0;
        alu_src_a    = SRCA_PC;
        alu_src_b    = SRCB_RD2;
        result_src   = RES_ALUOUT;
        imm_src      = IMM_I;
        w_alu_op     = ALUOP_ADD;
        w_retire     = 1'b0;
        w_waiting    = 1'b0;

        case (state_q)
            FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRCB_STEP;
                result_src = RES_ALURES;
                w_waiting  = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_B;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECR;
                    OP_I:         state_d = EXECI;
                    OP_BRANCH:    state_d = BRANCH;
                    OP_JAL:       state_d = JAL;
                    default: begin
                        state_d      = TRAP;
                        trap_cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                imm_src   = (op == OP_SW) ? IMM_S : IMM_I;
                state_d   = (op == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_req   = 1'b1;
                adr_src   = 1'b1;
                w_waiting = 1'b1;
                if (mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                state_d    = FETCH;
                w_retire   = 1'b1;
            end
            MEMWRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                adr_src   = 1'b1;
                w_waiting = 1'b1;
                if (mem_ready) begin
                    state_d  = FETCH;
                    w_retire = 1'b1;
                end
            end
            EXECR: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_RD2;
                w_alu_op  = ALUOP_FUNCT;
                state_d   = ALUWB;
            end
            EXECI: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_I;
                w_alu_op  = ALUOP_FUNCT;
                state_d   = ALUWB;
            end
            ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                state_d    = FETCH;
                w_retire   = 1'b1;
            end
            BRANCH: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_RD2;
                w_alu_op  = ALUOP_SUB;
                pc_write  = (funct3 == 3'b000 && zero) || (funct3 == 3'b001 && !zero);
                state_d   = FETCH;
                w_retire  = 1'b1;
            end
            JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_STEP;
                result_src = RES_ALUOUT;
                imm_src    = IMM_J;
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                state_d    = FETCH;
                w_retire   = 1'b1;
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        // A ready on the expiry cycle completes the access, so the trap only fires while still stalled
        wait_d = '0;
        if (w_waiting && !mem_ready) begin
            if (wait_q == C_WAIT_LIMIT) begin
                state_d      = TRAP;
                trap_cause_d = CAUSE_TIMEOUT;
            end else begin
                wait_d = wait_q + TO_W'(1);
            end
        end

        retired_d = w_retire ? retired_q + RET_W'(1) : retired_q;
    end

    assign retired    = retired_q;
    assign trap       = (state_q == TRAP);
    assign trap_cause = trap_cause_q;

endmodule

`default_nettype wire

// File: tb/tb_rv_multicycle_ctrl.sv
// ============================================================================
// Module      : tb_rv_multicycle_ctrl
// Description : Directed self-checking bench for rv_multicycle_ctrl
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv_multicycle_ctrl;

    localparam int RET_W   = 4;
    localparam int TIMEOUT = 4;
    localparam int TO_W    = 3;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    // {op, funct3, funct7b5, expected alu_control}
    localparam logic [13:0] ALU_VEC [7] = '{
        {OP_R, 3'b000, 1'b1, 3'b001},
        {OP_R, 3'b010, 1'b0, 3'b101},
        {OP_R, 3'b110, 1'b0, 3'b011},
        {OP_R, 3'b111, 1'b0, 3'b010},
        {OP_R, 3'b100, 1'b0, 3'b000},
        {OP_I, 3'b000, 1'b1, 3'b000},
        {OP_I, 3'b010, 1'b0, 3'b101}
    };

    // {funct3, zero, expected pc_write}
    localparam logic [4:0] BR_VEC [4] = '{
        {3'b000, 1'b1, 1'b1},
        {3'b001, 1'b1, 1'b0},
        {3'b001, 1'b0, 1'b1},
        {3'b100, 1'b0, 1'b0}
    };

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [6:0]       op = '0;
    logic [2:0]       funct3 = '0;
    logic             funct7b5 = 1'b0;
    logic             zero = 1'b0;
    logic             mem_ready = 1'b0;
    logic             mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]       alu_src_a, alu_src_b, result_src;
    logic [2:0]       imm_src, alu_control;
    logic [RET_W-1:0] retired;
    logic             trap;
    logic [1:0]       trap_cause;

    int               checks = 0;
    int               failures = 0;
    logic [RET_W-1:0] exp_ret = '0;

    always #5 clk = ~clk;

    rv_multicycle_ctrl #(.RET_W(RET_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .imm_src(imm_src), .alu_control(alu_control),
        .retired(retired), .trap(trap), .trap_cause(trap_cause)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        mem_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        exp_ret = '0;
    endtask

    task automatic run_instr(input logic [6:0] o, input int ncyc);
        op = o; funct3 = 3'b000; funct7b5 = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < ncyc; i++) tick();
        exp_ret = exp_ret + 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        op = OP_R; #1;
        checks++; if ({mem_req, adr_src} !== 2'b10) begin failures++; $display("FAIL reset_req_adr got=%b exp=10", {mem_req, adr_src}); end
        checks++; if ({alu_src_a, alu_src_b, result_src} !== 6'b001010) begin failures++; $display("FAIL reset_fetch_sel got=%b exp=001010", {alu_src_a, alu_src_b, result_src}); end
        checks++; if (retired !== 4'd0) begin failures++; $display("FAIL reset_retired got=%0d exp=0", retired); end
        checks++; if ({trap, trap_cause} !== 3'b000) begin failures++; $display("FAIL reset_trap got=%b exp=000", {trap, trap_cause}); end
        checks++; if ({ir_write, pc_write, reg_write, mem_we} !== 4'b0000) begin failures++; $display("FAIL reset_stall_en got=%b exp=0000", {ir_write, pc_write, reg_write, mem_we}); end
    endtask

    task automatic test_rtype();
        op = OP_R; funct3 = 3'b000; funct7b5 = 1'b0; mem_ready = 1'b1; #1;
        checks++; if ({ir_write, pc_write, reg_write} !== 3'b110) begin failures++; $display("FAIL r_fetch_en got=%b exp=110", {ir_write, pc_write, reg_write}); end
        tick();
        checks++; if ({mem_req, reg_write, alu_src_a, alu_src_b, imm_src} !== 9'b000101010) begin failures++; $display("FAIL r_decode got=%b exp=000101010", {mem_req, reg_write, alu_src_a, alu_src_b, imm_src}); end
        tick();
        checks++; if ({reg_write, alu_src_a, alu_src_b, alu_control} !== 8'b01000000) begin failures++; $display("FAIL r_execr got=%b exp=01000000", {reg_write, alu_src_a, alu_src_b, alu_control}); end
        tick();
        checks++; if ({reg_write, result_src, retired} !== 7'b1000000) begin failures++; $display("FAIL r_aluwb got=%b exp=1000000", {reg_write, result_src, retired}); end
        tick();
        exp_ret = 4'd1;
        checks++; if ({mem_req, reg_write, retired} !== {2'b10, exp_ret}) begin failures++; $display("FAIL r_retire got=%b exp=%b", {mem_req, reg_write, retired}, {2'b10, exp_ret}); end
    endtask

    task automatic test_alu_decode();
        logic [13:0] v;
        for (int i = 0; i < 7; i++) begin
            v = ALU_VEC[i];
            op = v[13:7]; funct3 = v[6:4]; funct7b5 = v[3]; mem_ready = 1'b1;
            tick();
            tick();
            checks++; if (alu_control !== v[2:0]) begin failures++; $display("FAIL alu_dec[%0d] got=%b exp=%b", i, alu_control, v[2:0]); end
            checks++; if (alu_src_b !== ((v[13:7] == OP_I) ? 2'b01 : 2'b00)) begin failures++; $display("FAIL alu_srcb[%0d] got=%b", i, alu_src_b); end
            tick();
            tick();
            exp_ret = exp_ret + 1'b1;
        end
        checks++; if (retired !== exp_ret) begin failures++; $display("FAIL alu_retired got=%0d exp=%0d", retired, exp_ret); end
    endtask

    task automatic test_lw();
        logic [9:0] rdy;
        int         irw;
        rdy = 10'b0100001000;
        irw = 0;
        op = OP_LW; funct3 = 3'b010;
        for (int i = 0; i < 10; i++) begin
            mem_ready = rdy[i]; #1;
            irw += int'(ir_write);
            if (i == 5) begin
                checks++; if ({imm_src, alu_src_a, alu_src_b} !== 7'b0001001) begin failures++; $display("FAIL lw_memadr got=%b exp=0001001", {imm_src, alu_src_a, alu_src_b}); end
            end
            if (i == 6) begin
                checks++; if ({mem_req, adr_src, mem_we} !== 3'b110) begin failures++; $display("FAIL lw_memread got=%b exp=110", {mem_req, adr_src, mem_we}); end
            end
            if (i == 9) begin
                checks++; if ({result_src, reg_write, trap, retired} !== {4'b0110, exp_ret}) begin failures++; $display("FAIL lw_memwb got=%b exp=%b", {result_src, reg_write, trap, retired}, {4'b0110, exp_ret}); end
            end
            tick();
        end
        exp_ret = exp_ret + 1'b1;
        checks++; if (irw !== 1) begin failures++; $display("FAIL lw_ir_pulses got=%0d exp=1", irw); end
        checks++; if ({mem_req, adr_src, retired} !== {2'b10, exp_ret}) begin failures++; $display("FAIL lw_retire got=%b exp=%b", {mem_req, adr_src, retired}, {2'b10, exp_ret}); end
    endtask

    task automatic test_sw();
        op = OP_SW; funct3 = 3'b010; mem_ready = 1'b1;
        tick();
        tick();
        checks++; if ({imm_src, alu_src_a, alu_src_b} !== 7'b0011001) begin failures++; $display("FAIL sw_memadr got=%b exp=0011001", {imm_src, alu_src_a, alu_src_b}); end
        tick();
        checks++; if ({mem_req, mem_we, adr_src, reg_write} !== 4'b1110) begin failures++; $display("FAIL sw_memwrite got=%b exp=1110", {mem_req, mem_we, adr_src, reg_write}); end
        tick();
        exp_ret = exp_ret + 1'b1;
        checks++; if ({mem_we, retired} !== {1'b0, exp_ret}) begin failures++; $display("FAIL sw_retire got=%b exp=%b", {mem_we, retired}, {1'b0, exp_ret}); end
    endtask

    task automatic test_branch();
        logic [4:0] v;
        for (int i = 0; i < 4; i++) begin
            v = BR_VEC[i];
            op = OP_BR; funct3 = v[4:2]; zero = v[1]; mem_ready = 1'b1;
            tick();
            tick();
            checks++; if ({pc_write, reg_write, alu_control} !== {v[0], 1'b0, 3'b001}) begin failures++; $display("FAIL branch[%0d] got=%b exp=%b", i, {pc_write, reg_write, alu_control}, {v[0], 1'b0, 3'b001}); end
            tick();
            exp_ret = exp_ret + 1'b1;
            checks++; if (retired !== exp_ret) begin failures++; $display("FAIL branch_retire[%0d] got=%0d exp=%0d", i, retired, exp_ret); end
        end
        zero = 1'b0;
    endtask

    task automatic test_jal();
        op = OP_JAL; funct3 = 3'b000; mem_ready = 1'b1;
        tick();
        tick();
        checks++; if ({pc_write, reg_write, imm_src, alu_src_a, alu_src_b, result_src} !== 11'b11011011000) begin failures++; $display("FAIL jal got=%b exp=11011011000", {pc_write, reg_write, imm_src, alu_src_a, alu_src_b, result_src}); end
        tick();
        exp_ret = exp_ret + 1'b1;
        checks++; if (retired !== exp_ret) begin failures++; $display("FAIL jal_retire got=%0d exp=%0d", retired, exp_ret); end
    endtask

    task automatic test_illegal();
        int bad;
        apply_reset();
        run_instr(OP_R, 4);
        op = OP_BAD; mem_ready = 1'b1;
        tick();
        tick();
        checks++; if ({trap, trap_cause} !== 3'b101) begin failures++; $display("FAIL illegal_trap got=%b exp=101", {trap, trap_cause}); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0]; op = OP_R; #1;
            if (mem_req !== 1'b0 || trap !== 1'b1 || {ir_write, pc_write, reg_write} !== 3'b000) bad++;
            tick();
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL illegal_hold got=%0d bad cycles exp=0", bad); end
        checks++; if (retired !== exp_ret) begin failures++; $display("FAIL illegal_retired got=%0d exp=%0d", retired, exp_ret); end
    endtask

    task automatic test_timeout();
        apply_reset();
        op = OP_R; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if ({trap, mem_req} !== 2'b01) begin failures++; $display("FAIL to_wait[%0d] got=%b exp=01", i, {trap, mem_req}); end
            tick();
        end
        checks++; if ({trap, trap_cause, mem_req} !== 4'b1100) begin failures++; $display("FAIL to_trap got=%b exp=1100", {trap, trap_cause, mem_req}); end
        apply_reset();
        checks++; if ({trap, trap_cause} !== 3'b000) begin failures++; $display("FAIL to_reset_clear got=%b exp=000", {trap, trap_cause}); end
        for (int i = 0; i < 3; i++) tick();
        mem_ready = 1'b1; #1;
        checks++; if (ir_write !== 1'b1) begin failures++; $display("FAIL to_late_ready got=%b exp=1", ir_write); end
        tick();
        checks++; if ({trap, mem_req, alu_src_a} !== 4'b0001) begin failures++; $display("FAIL to_decode got=%b exp=0001", {trap, mem_req, alu_src_a}); end
    endtask

    task automatic test_retire_wrap();
        apply_reset();
        for (int i = 0; i < 17; i++) run_instr(OP_R, 4);
        checks++; if (retired !== 4'd1) begin failures++; $display("FAIL retire_wrap got=%0d exp=1", retired); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        run_instr(OP_R, 4);
        op = OP_SW; mem_ready = 1'b1;
        tick();
        tick();
        tick();
        mem_ready = 1'b0; #1;
        checks++; if ({mem_we, retired} !== {1'b1, 4'd1}) begin failures++; $display("FAIL mid_memwrite got=%b exp=10001", {mem_we, retired}); end
        rst = 1'b0;
        tick();
        checks++; if ({mem_we, mem_req, adr_src, retired} !== {3'b010, 4'd0}) begin failures++; $display("FAIL mid_reset got=%b exp=0100000", {mem_we, mem_req, adr_src, retired}); end
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_alu_decode();
        test_lw();
        test_sw();
        test_branch();
        test_jal();
        test_illegal();
        test_timeout();
        test_retire_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
